// File: rtl/cdc_handshake_dest_arb.sv
// Destination side of a multi-channel 4-phase CDC handshake with round-robin merge.
// Optional ack-timeout flags: define CDC_HS_ACK_TIMEOUT_EN.
module cdc_handshake_dest_arb #(
   parameter int NumCh      = 4,
   parameter int DataWidth  = 32,
   parameter int SyncStage  = 2,
   parameter int AckTimeout = 255,
   localparam int ChW       = (NumCh > 1) ? $clog2(NumCh) : 1
) (
   input  logic                       dest_clk,
   input  logic                       reset,
   input  logic [NumCh-1:0]           src_hs_valid_i,
   input  logic [NumCh*DataWidth-1:0] src_hs_data_i,
   output logic [NumCh-1:0]           dest_hs_ready_o,
   output logic                       dest_valid_o,
   input  logic                       dest_ready_i,
   output logic [DataWidth-1:0]       dest_data_o,
   output logic [ChW-1:0]             dest_ch_o,
   output logic [NumCh-1:0]           err_timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t               state_q [NumCh];
   state_t               state_d [NumCh];
   logic [SyncStage-1:0] sync_q  [NumCh];
   logic [DataWidth-1:0] src_data [NumCh];

   logic [NumCh-1:0] vs;
   logic [NumCh-1:0] req;
   logic             slot_free;
   logic             accept;
   logic             found;
   logic             take;
   logic [ChW-1:0]   grant_idx;
   logic [ChW-1:0]   ptr_q;
   logic [ChW-1:0]   ptr_nxt;

   always_ff @(posedge dest_clk) begin
      for (int k = 0; k < NumCh; k++) begin
         if (reset) sync_q[k] <= '0;
         else       sync_q[k] <= {sync_q[k][SyncStage-2:0], src_hs_valid_i[k]};
      end
   end

   always_comb begin
      vs  = '0;
      req = '0;
      for (int k = 0; k < NumCh; k++) begin
         vs[k]       = sync_q[k][SyncStage-1];
         req[k]      = (state_q[k] == IDLE) && vs[k];
         src_data[k] = src_hs_data_i[k*DataWidth +: DataWidth];
      end
   end

   assign slot_free = !dest_valid_o || dest_ready_i;
   assign accept    = dest_valid_o && dest_ready_i;

   // First requester at or above the pointer, wrapping to zero.
   always_comb begin
      int idx;
      idx       = 0;
      found     = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NumCh; i++) begin
         idx = (int'(ptr_q) + i) % NumCh;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = ChW'(idx);
         end
      end
   end

   assign take    = found && slot_free;
   assign ptr_nxt = (grant_idx == ChW'(NumCh - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      for (int k = 0; k < NumCh; k++) begin
         state_d[k] = state_q[k];
         unique case (state_q[k])
            IDLE: if (take && grant_idx == ChW'(k)) state_d[k] = BUSY;
            BUSY: if (accept && dest_ch_o == ChW'(k)) state_d[k] = ACK;
            ACK:  if (!vs[k]) state_d[k] = IDLE;
            default: state_d[k] = IDLE;
         endcase
      end
   end

   always_ff @(posedge dest_clk) begin
      for (int k = 0; k < NumCh; k++) begin
         if (reset) begin
            state_q[k]         <= IDLE;
            dest_hs_ready_o[k] <= 1'b0;
         end else begin
            state_q[k]         <= state_d[k];
            dest_hs_ready_o[k] <= (state_d[k] == ACK);
         end
      end
   end

   always_ff @(posedge dest_clk) begin
      if (reset) begin
         dest_valid_o <= 1'b0;
         dest_data_o  <= '0;
         dest_ch_o    <= '0;
         ptr_q        <= '0;
      end else if (take) begin
         dest_valid_o <= 1'b1;
         dest_data_o  <= src_data[grant_idx];
         dest_ch_o    <= grant_idx;
         ptr_q        <= ptr_nxt;
      end else if (dest_ready_i) begin
         dest_valid_o <= 1'b0;
      end
   end

`ifdef CDC_HS_ACK_TIMEOUT_EN
   localparam int CntW = $clog2(AckTimeout + 1);

   logic [CntW-1:0]  cnt_q [NumCh];
   logic [NumCh-1:0] err_q;

   // Counter rests at zero outside ACK, so it starts from zero on entry.
   always_ff @(posedge dest_clk) begin
      for (int k = 0; k < NumCh; k++) begin
         if (reset) begin
            cnt_q[k] <= '0;
            err_q[k] <= 1'b0;
         end else begin
            if (state_q[k] != ACK)
               cnt_q[k] <= '0;
            else if (cnt_q[k] != CntW'(AckTimeout))
               cnt_q[k] <= cnt_q[k] + 1'b1;
            if (cnt_q[k] == CntW'(AckTimeout))
               err_q[k] <= 1'b1;
         end
      end
   end

   assign err_timeout_o = err_q;
`else
   assign err_timeout_o = '0;
`endif

endmodule

// File: tb/tb_cdc_handshake_dest_arb.sv
// Bench for cdc_handshake_dest_arb: directed latency/order cases plus
// randomized 4-phase sources against a per-channel expected-payload scoreboard.
module tb_cdc_handshake_dest_arb;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int S  = 2;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   src_v;
   logic [N*W-1:0] src_d;
   logic [N-1:0]   hs_ready;
   logic           dvalid;
   logic           ready_i;
   logic [W-1:0]   ddata;
   logic [1:0]     dch;
   logic [N-1:0]   err;

   logic [N-1:0]   mv;
   logic [N-1:0]   av;
   logic [N-1:0]   auto_en;
   logic [W-1:0]   md [N];
   logic [W-1:0]   ad [N];

   logic           sb_on, log_on, eager, stop_new;
   logic           held;
   logic [W-1:0]   held_d;
   logic [1:0]     held_ch;
   logic [W-1:0]   expq [N][$];
   int             beat_log[$];
   int             beats;
   int             tests = 0;
   int             fails = 0;

   always #5 clk = ~clk;

   assign src_v = (av & auto_en) | (mv & ~auto_en);

   always_comb begin
      src_d = '0;
      for (int k = 0; k < N; k++)
         src_d[k*W +: W] = auto_en[k] ? ad[k] : md[k];
   end

   cdc_handshake_dest_arb #(
      .NumCh(N), .DataWidth(W), .SyncStage(S), .AckTimeout(TO)
   ) dut (
      .dest_clk(clk),
      .reset(reset),
      .src_hs_valid_i(src_v),
      .src_hs_data_i(src_d),
      .dest_hs_ready_o(hs_ready),
      .dest_valid_o(dvalid),
      .dest_ready_i(ready_i),
      .dest_data_o(ddata),
      .dest_ch_o(dch),
      .err_timeout_o(err)
   );

   // Behavioural 4-phase sources: raise with fresh data, drop after ack.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < N; k++) begin
         if (auto_en[k]) begin
            if (!av[k] && !hs_ready[k] && !stop_new &&
                (eager || $urandom_range(0, 2) != 0)) begin
               ad[k] = $urandom;
               av[k] = 1'b1;
               expq[k].push_back(ad[k]);
            end else if (av[k] && hs_ready[k] &&
                         (eager || $urandom_range(0, 2) != 0)) begin
               av[k] = 1'b0;
            end
         end
      end
   end

   // Scoreboard: each accepted beat must be the oldest unsent request of its channel.
   always @(negedge clk) begin
      if (sb_on) begin
         if (held) begin
            tests++;
            if (dvalid !== 1'b1 || ddata !== held_d || dch !== held_ch) begin
               fails++;
               $display("FAIL stall_stable: valid=%0b data=%h ch=%0d required 1/%h/%0d",
                        dvalid, ddata, dch, held_d, held_ch);
            end
         end
         if (dvalid && ready_i) begin
            tests++;
            beats++;
            if (expq[dch].size() == 0) begin
               fails++;
               $display("FAIL beat_dup: ch=%0d data=%h required no beat", dch, ddata);
            end else begin
               if (expq[dch][0] !== ddata) begin
                  fails++;
                  $display("FAIL beat_data: ch=%0d data=%h required %h",
                           dch, ddata, expq[dch][0]);
               end
               void'(expq[dch].pop_front());
            end
         end
         held    = dvalid && !ready_i;
         held_d  = ddata;
         held_ch = dch;
      end else begin
         held = 1'b0;
      end
      if (log_on && dvalid && ready_i) beat_log.push_back(int'(dch));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      mv       = '0;
      av       = '0;
      auto_en  = '0;
      ready_i  = 1'b0;
      stop_new = 1'b0;
      eager    = 1'b0;
      sb_on    = 1'b0;
      log_on   = 1'b0;
      for (int k = 0; k < N; k++) begin
         md[k] = '0;
         ad[k] = '0;
         expq[k].delete();
      end
      tick(2);
      reset = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done     = 1'b0;
      stop_new = 1'b1;
      ready_i  = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         done = (av == '0) && (hs_ready == '0) && !dvalid;
         for (int k = 0; k < N; k++)
            if (expq[k].size() != 0) done = 1'b0;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL drain: av=%b hs_ready=%b valid=%0b required all idle",
                  av, hs_ready, dvalid);
      end
      tick(1);
      auto_en  = '0;
      stop_new = 1'b0;
      eager    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick(1);
      tests++;
      if ({dvalid, ddata, dch, hs_ready, err} !== '0) begin
         fails++;
         $display("FAIL reset_state: valid=%0b data=%h ch=%0d rdy=%b err=%b required 0",
                  dvalid, ddata, dch, hs_ready, err);
      end
   endtask

   task automatic test_single();
      do_reset();
      md[2]   = 32'hA5A5_0002;
      mv[2]   = 1'b1;
      ready_i = 1'b1;
      tick(S);
      tests++;
      if (dvalid !== 1'b0) begin
         fails++;
         $display("FAIL single_early: valid=%0b required 0", dvalid);
      end
      tick(1);
      tests++;
      if (dvalid !== 1'b1 || ddata !== 32'hA5A5_0002 || dch !== 2'd2) begin
         fails++;
         $display("FAIL single_beat: valid=%0b data=%h ch=%0d required 1/a5a50002/2",
                  dvalid, ddata, dch);
      end
      tick(1);
      tests++;
      if (hs_ready !== 4'b0100 || dvalid !== 1'b0) begin
         fails++;
         $display("FAIL single_ack: rdy=%b valid=%0b required 0100/0", hs_ready, dvalid);
      end
      mv[2] = 1'b0;
      tick(S);
      tests++;
      if (hs_ready !== 4'b0100) begin
         fails++;
         $display("FAIL single_ack_hold: rdy=%b required 0100", hs_ready);
      end
      tick(1);
      tests++;
      if (hs_ready !== 4'b0000) begin
         fails++;
         $display("FAIL single_ack_drop: rdy=%b required 0000", hs_ready);
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int k = 0; k < N; k++) md[k] = 32'hC0DE_0000 + k;
      mv      = '1;
      ready_i = 1'b1;
      tick(S + 1);
      for (int k = 0; k < N; k++) begin
         tests++;
         if (dvalid !== 1'b1 || dch !== 2'(k) || ddata !== 32'hC0DE_0000 + k) begin
            fails++;
            $display("FAIL contention_%0d: valid=%0b ch=%0d data=%h required 1/%0d/%h",
                     k, dvalid, dch, ddata, k, 32'hC0DE_0000 + k);
         end
         tick(1);
      end
      tests++;
      if (dvalid !== 1'b0 || hs_ready !== 4'hF) begin
         fails++;
         $display("FAIL contention_end: valid=%0b rdy=%b required 0/1111", dvalid, hs_ready);
      end
      mv = '0;
      tick(S + 2);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d;
      do_reset();
      d       = $urandom;
      md[1]   = d;
      mv[1]   = 1'b1;
      ready_i = 1'b0;
      tick(S + 1);
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (dvalid !== 1'b1 || ddata !== d || dch !== 2'd1 || hs_ready !== '0) begin
            fails++;
            $display("FAIL stall_%0d: valid=%0b data=%h ch=%0d rdy=%b required 1/%h/1/0000",
                     c, dvalid, ddata, dch, hs_ready, d);
         end
         tick(1);
      end
      ready_i = 1'b1;
      tick(1);
      tests++;
      if (hs_ready !== 4'b0010 || dvalid !== 1'b0) begin
         fails++;
         $display("FAIL stall_ack: rdy=%b valid=%0b required 0010/0", hs_ready, dvalid);
      end
      mv[1] = 1'b0;
      tick(S + 2);
      tests++;
      if (hs_ready !== '0) begin
         fails++;
         $display("FAIL stall_release: rdy=%b required 0000", hs_ready);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      beat_log.delete();
      beats   = 0;
      eager   = 1'b1;
      ready_i = 1'b1;
      sb_on   = 1'b1;
      log_on  = 1'b1;
      @(negedge clk);
      auto_en = 4'b1000;
      @(negedge clk);
      auto_en = 4'b1001;
      for (int c = 0; c < 300 && beat_log.size() < 8; c++) @(negedge clk);
      tests++;
      if (beat_log.size() < 8) begin
         fails++;
         $display("FAIL fair_count: beats=%0d required 8", beat_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests++;
            if (beat_log[i] != ((i % 2 == 0) ? 3 : 0)) begin
               fails++;
               $display("FAIL fair_order_%0d: ch=%0d required %0d",
                        i, beat_log[i], (i % 2 == 0) ? 3 : 0);
            end
         end
      end
      drain();
      sb_on  = 1'b0;
      log_on = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [W-1:0] d;
      do_reset();
      d       = $urandom;
      md[1]   = d;
      mv[1]   = 1'b1;
      tick(S + 1);
      reset = 1'b1;
      tick(1);
      tests++;
      if ({dvalid, ddata, dch, hs_ready, err} !== '0) begin
         fails++;
         $display("FAIL midreset_clear: valid=%0b data=%h ch=%0d rdy=%b required 0",
                  dvalid, ddata, dch, hs_ready);
      end
      reset = 1'b0;
      tick(S + 1);
      tests++;
      if (dvalid !== 1'b1 || ddata !== d || dch !== 2'd1) begin
         fails++;
         $display("FAIL midreset_redeliver: valid=%0b data=%h ch=%0d required 1/%h/1",
                  dvalid, ddata, dch, d);
      end
      ready_i = 1'b1;
      tick(1);
      tests++;
      if (hs_ready !== 4'b0010) begin
         fails++;
         $display("FAIL midreset_ack: rdy=%b required 0010", hs_ready);
      end
      mv[1] = 1'b0;
      tick(S + 2);
   endtask

   task automatic test_timeout();
      logic [N-1:0] exp_err;
`ifdef CDC_HS_ACK_TIMEOUT_EN
      exp_err = 4'b0001;
`else
      exp_err = 4'b0000;
`endif
      do_reset();
      md[0]   = 32'h7777_0000;
      mv[0]   = 1'b1;
      ready_i = 1'b1;
      tick(S + 2);
      tick(4);
      tests++;
      if (err !== '0) begin
         fails++;
         $display("FAIL timeout_early: err=%b required 0000", err);
      end
      tick(TO);
      tests++;
      if (err !== exp_err || hs_ready !== 4'b0001) begin
         fails++;
         $display("FAIL timeout_flag: err=%b rdy=%b required %b/0001", err, hs_ready, exp_err);
      end
      mv[0] = 1'b0;
      tick(S + 2);
      tests++;
      if (err !== exp_err || hs_ready !== '0) begin
         fails++;
         $display("FAIL timeout_sticky: err=%b rdy=%b required %b/0000", err, hs_ready, exp_err);
      end
      do_reset();
      tests++;
      if (err !== '0) begin
         fails++;
         $display("FAIL timeout_reset: err=%b required 0000", err);
      end
   endtask

   task automatic test_random();
      do_reset();
      beats   = 0;
      sb_on   = 1'b1;
      auto_en = '1;
      for (int c = 0; c < 600; c++) begin
         ready_i = ($urandom_range(0, 9) < 7);
         tick(1);
      end
      drain();
      tests++;
      if (beats < 20) begin
         fails++;
         $display("FAIL random_beats: beats=%0d required at least 20", beats);
      end
      sb_on = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_fairness();
      test_reset_midop();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
